// File: rtl/sync_fifo_pkg.sv
// Shared helpers for the sync_fifo subsystem: pointer width and configuration legality.
package sync_fifo_pkg;

  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

  function automatic bit cfg_ok(input int depth, input int afull_th, input int aempty_th);
    return is_pow2(depth) && (depth >= 4) && (afull_th <= depth) && (aempty_th < afull_th);
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x WIDTH simple dual-port storage: synchronous write, registered read port.
module sync_fifo_mem #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Array is deliberately unreset so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Same-address write/read returns the old word, which is what a full FIFO needs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised synchronous FIFO: pointers, occupancy, flags, sticky errors, flush.
// Define SYNC_FIFO_ASSERT_EN to compile in the embedded protocol assertions.
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 16,
  parameter int AFULL_TH  = 12,
  parameter int AEMPTY_TH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      fifo_write,
  input  logic [WIDTH-1:0]          fifo_data_in,
  input  logic                      fifo_read,
  output logic [WIDTH-1:0]          fifo_data_out,
  output logic                      rd_valid,
  output logic                      fifo_full,
  output logic                      fifo_empty,
  output logic                      afull,
  output logic                      aempty,
  output logic [ptr_w(DEPTH)-1:0]   cnt,
  output logic                      ovf_err,
  output logic                      udf_err
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;
  localparam logic [PW-1:0] DEPTH_C  = PW'(DEPTH);
  localparam logic [PW-1:0] AFULL_C  = PW'(AFULL_TH);
  localparam logic [PW-1:0] AEMPTY_C = PW'(AEMPTY_TH);

  if (!cfg_ok(DEPTH, AFULL_TH, AEMPTY_TH)) begin : g_cfg_err
    $error("sync_fifo_param: illegal DEPTH / threshold configuration");
  end

  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, cnt_q, cnt_d;
  logic          ovf_q, ovf_d, udf_q, udf_d, rd_valid_q;
  logic          wr_acc, rd_acc;

  assign fifo_full  = (cnt_q == DEPTH_C);
  assign fifo_empty = (cnt_q == '0);
  assign afull      = (cnt_q >= AFULL_C);
  assign aempty     = (cnt_q <= AEMPTY_C);

  // A write into a full FIFO is fine when a read frees the slot on the same edge.
  assign wr_acc = !flush && fifo_write && (!fifo_full || fifo_read);
  assign rd_acc = !flush && fifo_read && !fifo_empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + PW'(1);
      if (rd_acc) rd_ptr_d = rd_ptr_q + PW'(1);
      cnt_d = cnt_q + PW'(wr_acc) - PW'(rd_acc);
      if (fifo_write && fifo_full && !fifo_read) ovf_d = 1'b1;
      if (fifo_read && fifo_empty)               udf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
      rd_valid_q <= rd_acc;
    end
  end

  sync_fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk     (clk),
    .rst     (rst),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (fifo_data_in),
    .re_i    (rd_acc),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (fifo_data_out)
  );

  assign rd_valid = rd_valid_q;
  assign cnt      = cnt_q;
  assign ovf_err  = ovf_q;
  assign udf_err  = udf_q;

`ifdef SYNC_FIFO_ASSERT_EN
  a_empty_dec: assert property (@(posedge clk) disable iff (rst)
    (cnt_q == '0) == fifo_empty);
  a_full_dec: assert property (@(posedge clk) disable iff (rst)
    (cnt_q == DEPTH_C) == fifo_full);
  a_ovf_hold: assert property (@(posedge clk) disable iff (rst)
    (fifo_write && fifo_full && !fifo_read && !flush) |=> $stable(wr_ptr_q));
  a_udf_hold: assert property (@(posedge clk) disable iff (rst)
    (fifo_read && fifo_empty && !flush && !fifo_write) |=> $stable(rd_ptr_q));
  a_cnt_max: assert property (@(posedge clk) disable iff (rst)
    cnt_q <= DEPTH_C);
`endif

endmodule
